// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: latched call inputs and car status outputs of the elevator scheduler.
interface elevator_scheduler_if;
    logic [13:0] floorButton;
    logic [9:1]  internalButton;
    logic [2:0]  currentFloor;
    logic [1:0]  currentDirection;
    logic        doorState;
    logic        move;
    logic        buttonEnable;
    modport master (
        output floorButton, internalButton,
        input  currentFloor, currentDirection, doorState, move, buttonEnable
    );
    modport slave (
        input  floorButton, internalButton,
        output currentFloor, currentDirection, doorState, move, buttonEnable
    );
endinterface

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN car-motion scheduler for a 2-way 7-floor elevator.
// Optional ELEV_IDLE_HOME_EN: return the car to floor 1 after IDLE_TICKS request-free idle cycles.
module elevator_scheduler #(
    parameter int DOOR_TICKS   = 8,
    parameter int TRAVEL_TICKS = 16,
    parameter int IDLE_TICKS   = 64
) (
    input logic clk,
    input logic reset,
    elevator_scheduler_if.slave bus_io
);
    localparam int MAXT2 = DOOR_TICKS > TRAVEL_TICKS ? DOOR_TICKS : TRAVEL_TICKS;
`ifdef ELEV_IDLE_HOME_EN
    localparam int MAXT = MAXT2 > IDLE_TICKS ? MAXT2 : IDLE_TICKS;
`else
    localparam int MAXT = MAXT2;
`endif
    localparam int CW = $clog2(MAXT + 1);
    localparam logic [CW-1:0] D1 = CW'(DOOR_TICKS - 1);
    localparam logic [CW-1:0] T1 = CW'(TRAVEL_TICKS - 1);
    localparam logic [1:0] STOP = 2'b00, UP = 2'b10, DN = 2'b01;

    if (DOOR_TICKS < 2 || TRAVEL_TICKS < 1 || IDLE_TICKS < 1) begin : g_bad_params
        $error("elevator_scheduler: invalid tick parameters");
    end

    typedef enum logic [1:0] {IDLE, OPEN, HOLD, MOVING} state_t;

    state_t        state_q, state_d;
    logic [2:0]    floor_q, floor_d;
    logic [1:0]    dir_q, dir_d;
    logic          door_q, door_d, move_q, move_d, ben_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:1]    hall_up, hall_dn, req;
    logic [2:0]    nf;
    logic          open_b, close_b, going_up, req_here, req_above, req_below;
    logic          ahead, behind, opp_here, nf_beyond, nf_match, nf_term, nf_others, nf_stop;

    // Floors strictly above / below x, as a mask over req[7:1]
    function automatic logic [7:1] mask_up(input logic [2:0] x);
        return 7'(8'h7F << x);
    endfunction
    function automatic logic [7:1] mask_dn(input logic [2:0] x);
        return 7'((8'h1 << (x - 3'd1)) - 8'h1);
    endfunction

    always_comb begin
        for (int f = 1; f <= 7; f++) begin
            hall_dn[f] = bus_io.floorButton[2*f-2];
            hall_up[f] = bus_io.floorButton[2*f-1];
        end
    end

    assign req       = hall_up | hall_dn | bus_io.internalButton[7:1];
    assign open_b    = bus_io.internalButton[8];
    assign close_b   = bus_io.internalButton[9];
    assign going_up  = dir_q == UP;
    assign req_here  = req[floor_q];
    assign req_above = |(req & mask_up(floor_q));
    assign req_below = |(req & mask_dn(floor_q));
    assign ahead     = going_up ? req_above : req_below;
    assign behind    = going_up ? req_below : req_above;
    assign opp_here  = going_up ? hall_dn[floor_q] : hall_up[floor_q];
    assign nf        = going_up ? floor_q + 3'd1 : floor_q - 3'd1;
    assign nf_beyond = |(req & (going_up ? mask_up(nf) : mask_dn(nf)));
    assign nf_match  = bus_io.internalButton[nf] | (going_up ? hall_up[nf] : hall_dn[nf]);
    assign nf_term   = nf == (going_up ? 3'd7 : 3'd1);
    assign nf_others = |(req & (mask_up(nf) | mask_dn(nf)));

`ifdef ELEV_IDLE_HOME_EN
    logic home_q, home_d;
    // A homing run stops for any outstanding request, not only those ahead
    assign nf_stop = home_q ? (|req || nf == 3'd1) : (nf_match | ~nf_beyond | nf_term);
`else
    assign nf_stop = nf_match | ~nf_beyond | nf_term;
`endif

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        door_d  = door_q;
        move_d  = move_q;
        cnt_d   = cnt_q;
`ifdef ELEV_IDLE_HOME_EN
        home_d  = home_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_here || open_b) begin
                    state_d = OPEN;
                    door_d  = 1'b1;
                    cnt_d   = D1;
                end else if (req_above || req_below) begin
                    state_d = MOVING;
                    dir_d   = req_above ? UP : DN;
                    move_d  = 1'b1;
                    cnt_d   = T1;
                end
`ifdef ELEV_IDLE_HOME_EN
                else if (cnt_q != CW'(IDLE_TICKS - 1)) cnt_d = cnt_q + 1'b1;
                else if (floor_q != 3'd1) begin
                    state_d = MOVING;
                    dir_d   = DN;
                    move_d  = 1'b1;
                    cnt_d   = T1;
                    home_d  = 1'b1;
                end
`endif
            end
            OPEN: begin
                if (close_b || (!open_b && !req_here && cnt_q == '0)) begin
                    state_d = HOLD;
                    door_d  = 1'b0;
                end else cnt_d = (open_b || req_here) ? D1 : cnt_q - 1'b1;
            end
            HOLD: begin
                if (open_b || (dir_q != STOP && !ahead && opp_here)) begin
                    state_d = OPEN;
                    door_d  = 1'b1;
                    cnt_d   = D1;
                    dir_d   = open_b ? dir_q : ~dir_q;
                end else if (dir_q != STOP && (ahead || behind)) begin
                    state_d = MOVING;
                    move_d  = 1'b1;
                    cnt_d   = T1;
                    dir_d   = ahead ? dir_q : ~dir_q;
                end else begin
                    state_d = IDLE;
                    dir_d   = STOP;
                    cnt_d   = '0;
                end
            end
            MOVING: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    floor_d = nf;
                    if (nf_stop) begin
                        state_d = OPEN;
                        move_d  = 1'b0;
                        door_d  = 1'b1;
                        cnt_d   = D1;
                        dir_d   = (nf_term && !nf_others) ? STOP : dir_q;
`ifdef ELEV_IDLE_HOME_EN
                        home_d  = 1'b0;
                        if (home_q && !req[nf]) begin
                            state_d = HOLD;
                            door_d  = 1'b0;
                        end
`endif
                    end else cnt_d = T1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            floor_q <= 3'd1;
            dir_q   <= STOP;
            door_q  <= 1'b0;
            move_q  <= 1'b0;
            cnt_q   <= '0;
            ben_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            door_q  <= door_d;
            move_q  <= move_d;
            cnt_q   <= cnt_d;
            ben_q   <= 1'b1;
        end
    end

`ifdef ELEV_IDLE_HOME_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) home_q <= 1'b0;
        else home_q <= home_d;
    end
`endif

    assign bus_io.currentFloor     = floor_q;
    assign bus_io.currentDirection = dir_q;
    assign bus_io.doorState        = door_q;
    assign bus_io.move             = move_q;
    assign bus_io.buttonEnable     = ben_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed table, corner sequences and a randomized run against a
// behavioural car model for elevator_scheduler.
`timescale 1ns/1ps
module tb_elevator_scheduler;
    localparam int DT = 8, TT = 16;
    localparam logic [1:0] STOP = 2'b00, UP = 2'b10, DN = 2'b01;
    localparam int P_IDLE = 0, P_DOOR = 1, P_PAUSE = 2, P_TRAVEL = 3;

    logic clk = 1'b0, reset = 1'b0;
    int nvec = 0, nerr = 0;

    elevator_scheduler_if bus();
    elevator_scheduler #(.DOOR_TICKS(DT), .TRAVEL_TICKS(TT), .IDLE_TICKS(64)) dut (
        .clk(clk), .reset(reset), .bus_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [13:0] fb;
        logic [9:1]  ib;
        int          n;
        logic [2:0]  fl;
        logic [1:0]  dir;
        logic        door;
        logic        mv;
    } vec_t;
    vec_t tbl[$];

    int m_floor, m_dir, m_phase, m_left;
    bit m_door, m_move;

    function automatic logic [9:1] car(int f);
        logic [9:1] v = '0;
        v[f] = 1'b1;
        return v;
    endfunction
    function automatic logic [13:0] hup(int f);
        return 14'(1) << (2*f - 1);
    endfunction
    function automatic logic [13:0] hdn(int f);
        return 14'(1) << (2*f - 2);
    endfunction
    function automatic vec_t mk(string t, logic [13:0] fb, logic [9:1] ib, int n,
                                logic [2:0] fl, logic [1:0] d, logic door, logic mv);
        vec_t v;
        v.tag = t; v.fb = fb; v.ib = ib; v.n = n; v.fl = fl; v.dir = d; v.door = door; v.mv = mv;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check_out(string tag, logic [2:0] fl, logic [1:0] d, logic door, logic mv);
        check({tag, ".state"}, {bus.currentFloor, bus.currentDirection, bus.doorState, bus.move},
              {fl, d, door, mv});
    endtask

    // Behavioural car model: plain floor arithmetic over the request set
    function automatic bit hall_up_at(int f);
        return bus.floorButton[2*f-1];
    endfunction
    function automatic bit hall_dn_at(int f);
        return bus.floorButton[2*f-2];
    endfunction
    function automatic bit rq(int f);
        return hall_up_at(f) | hall_dn_at(f) | bus.internalButton[f];
    endfunction
    function automatic bit any_rq(int lo, int hi);
        for (int f = lo; f <= hi; f++) if (f >= 1 && f <= 7 && rq(f)) return 1'b1;
        return 1'b0;
    endfunction
    task automatic model_reset();
        m_floor = 1; m_dir = 0; m_phase = P_IDLE; m_left = 0; m_door = 0; m_move = 0;
    endtask
    task automatic open_door();
        m_door = 1; m_phase = P_DOOR; m_left = DT;
    endtask
    task automatic pause();
        m_door = 0; m_phase = P_PAUSE;
    endtask
    task automatic depart(int d);
        m_dir = d; m_move = 1; m_phase = P_TRAVEL; m_left = TT;
    endtask
    task automatic arrive();
        int nf = m_floor + m_dir;
        bit beyond = (m_dir > 0) ? any_rq(nf + 1, 7) : any_rq(1, nf - 1);
        bit match = bus.internalButton[nf] | ((m_dir > 0) ? hall_up_at(nf) : hall_dn_at(nf));
        bit term = (nf == 1) || (nf == 7);
        m_floor = nf;
        if (match || !beyond || term) begin
            m_move = 0;
            if (term && !(any_rq(1, nf - 1) || any_rq(nf + 1, 7))) m_dir = 0;
            open_door();
        end else m_left = TT;
    endtask
    task automatic model_step();
        int fl = m_floor;
        bit ob = bus.internalButton[8];
        bit cb = bus.internalButton[9];
        bit above = any_rq(fl + 1, 7);
        bit below = any_rq(1, fl - 1);
        bit ahead = (m_dir > 0) ? above : below;
        bit behind = (m_dir > 0) ? below : above;
        bit opp = (m_dir > 0) ? hall_dn_at(fl) : hall_up_at(fl);
        case (m_phase)
            P_IDLE:
                if (rq(fl) || ob) open_door();
                else if (above) depart(1);
                else if (below) depart(-1);
            P_DOOR:
                if (cb) pause();
                else if (ob || rq(fl)) m_left = DT;
                else if (m_left == 1) pause();
                else m_left--;
            P_PAUSE:
                if (ob) open_door();
                else if (m_dir == 0) m_phase = P_IDLE;
                else if (ahead) depart(m_dir);
                else if (opp) begin m_dir = -m_dir; open_door(); end
                else if (behind) depart(-m_dir);
                else begin m_dir = 0; m_phase = P_IDLE; end
            default:
                if (m_left > 1) m_left--;
                else arrive();
        endcase
    endtask
    function automatic logic [1:0] m_dir_code();
        return m_dir > 0 ? UP : (m_dir < 0 ? DN : STOP);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.floorButton = '0;
        bus.internalButton = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bit seen4, got;
        bus.floorButton = '0;
        bus.internalButton = '0;
        tbl.push_back(mk("go4_start",  '0, car(4),  1, 3'd1, UP,   1'b0, 1'b1));
        tbl.push_back(mk("go4_travel", '0, car(4), 47, 3'd3, UP,   1'b0, 1'b1));
        tbl.push_back(mk("go4_arrive", '0, '0,      1, 3'd4, UP,   1'b1, 1'b0));
        tbl.push_back(mk("go4_open",   '0, '0,      7, 3'd4, UP,   1'b1, 1'b0));
        tbl.push_back(mk("go4_hold",   '0, '0,      1, 3'd4, UP,   1'b0, 1'b0));
        tbl.push_back(mk("go4_idle",   '0, '0,      1, 3'd4, STOP, 1'b0, 1'b0));
        tbl.push_back(mk("pick_up",    hup(2) | hdn(6), '0,  1, 3'd4, UP, 1'b0, 1'b1));
        tbl.push_back(mk("to6_mid",    hup(2) | hdn(6), '0, 31, 3'd5, UP, 1'b0, 1'b1));
        tbl.push_back(mk("at6_open",   hup(2) | hdn(6), '0,  1, 3'd6, UP, 1'b1, 1'b0));
        tbl.push_back(mk("at6_door",   hup(2), '0,  7, 3'd6, UP,   1'b1, 1'b0));
        tbl.push_back(mk("at6_hold",   hup(2), '0,  1, 3'd6, UP,   1'b0, 1'b0));
        tbl.push_back(mk("rev_down",   hup(2), '0,  1, 3'd6, DN,   1'b0, 1'b1));
        tbl.push_back(mk("to2_mid",    hup(2), '0, 63, 3'd3, DN,   1'b0, 1'b1));
        tbl.push_back(mk("at2_open",   hup(2), '0,  1, 3'd2, DN,   1'b1, 1'b0));
        tbl.push_back(mk("close_btn",  '0, car(9),  1, 3'd2, DN,   1'b0, 1'b0));
        tbl.push_back(mk("reopen_btn", '0, car(8),  1, 3'd2, DN,   1'b1, 1'b0));
        tbl.push_back(mk("reopen_len", '0, '0,      8, 3'd2, DN,   1'b0, 1'b0));
        tbl.push_back(mk("at2_idle",   '0, '0,      1, 3'd2, STOP, 1'b0, 1'b0));

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_out("reset", 3'd1, STOP, 1'b0, 1'b0);
        check("reset.ben", bus.buttonEnable, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.floorButton = tbl[i].fb;
            bus.internalButton = tbl[i].ib;
            repeat (tbl[i].n) @(negedge clk);
            check_out(tbl[i].tag, tbl[i].fl, tbl[i].dir, tbl[i].door, tbl[i].mv);
        end
        check("ben_after", bus.buttonEnable, 1'b1);

        // From idle at 2, heading up: pass the DOWN call at 4, serve 6, then come back for 4
        bus.floorButton = hdn(4);
        bus.internalButton = car(6);
        seen4 = 0; got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bus.doorState && bus.currentFloor == 3'd4) seen4 = 1;
            if (bus.doorState && bus.currentFloor == 3'd6) got = 1;
        end
        check("scan.skip4", seen4, 1'b0);
        check("scan.stop6", got, 1'b1);
        check("scan.dir6", bus.currentDirection, UP);
        bus.internalButton = '0;
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bus.doorState && bus.currentFloor == 3'd4) got = 1;
        end
        check("scan.stop4", got, 1'b1);
        check("scan.dir4", bus.currentDirection, DN);
        bus.floorButton = '0;

        // Terminal arrival with nothing else pending: STOP while the door is open
        bus.internalButton = car(7);
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bus.doorState && bus.currentFloor == 3'd7) got = 1;
        end
        check("term.stop7", got, 1'b1);
        check("term.dir", bus.currentDirection, STOP);
        bus.internalButton = '0;
        repeat (300) @(negedge clk);
`ifdef ELEV_IDLE_HOME_EN
        check_out("park", 3'd1, STOP, 1'b0, 1'b0);
`else
        check_out("park", 3'd7, STOP, 1'b0, 1'b0);
`endif

        // Asynchronous reset while travelling up past floor 3
        do_reset();
        bus.internalButton = car(5);
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.currentFloor == 3'd3 && bus.move) got = 1;
        end
        check("midtravel.reach3", got, 1'b1);
        #2 reset = 1'b1;
        #1 check_out("midtravel.reset", 3'd1, STOP, 1'b0, 1'b0);
        check("midtravel.ben", bus.buttonEnable, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.internalButton = '0;
        model_reset();

        // Randomized run; calls at the open floor are cleared as the latch block would
        for (int c = 0; c < 4000; c++) begin
            logic [13:0] fb = bus.floorButton;
            logic [7:1] cc = bus.internalButton[7:1];
            if ($urandom_range(0, 11) == 0) fb ^= 14'(1) << $urandom_range(0, 13);
            if ($urandom_range(0, 15) == 0) cc ^= 7'(1) << $urandom_range(0, 6);
            if ($urandom_range(0, 79) == 0) begin fb = '0; cc = '0; end
            if (m_door && $urandom_range(0, 2) == 0) begin
                fb &= ~(hup(m_floor) | hdn(m_floor));
                cc[m_floor] = 1'b0;
            end
            bus.floorButton = fb;
            bus.internalButton = {$urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, cc};
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("random", {bus.currentFloor, bus.currentDirection, bus.doorState, bus.move,
                             bus.buttonEnable, bus.doorState & bus.move},
                  {3'(m_floor), m_dir_code(), m_door, m_move, 1'b1, 1'b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
